seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller sharing one 7-segment decoder among `DIGITS` digit positions. It sits between the counter datapath and the single `seg7` decoder instance, and sequences which nibble the decoder sees and which digit enable is driven. Display updates are tear-free: new values are accepted through a valid/ready handshake and committed only at frame boundaries. Optional leading-zero blanking is supported.

---
 rtl/seg_scan_if.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bus between the counter datapath and the scan controller: value handshake in,
// scan/decoder drive out. The controller attaches through the slave modport.
`timescale 1ns/1ps
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  lz_blank_en;
  logic [4*DIGITS-1:0]   value;
  logic                  value_valid;
  logic                  value_ready;
  logic [3:0]            digit_code;
  logic [DIGITS-1:0]     digit_sel;
  logic                  digit_blank;
  logic                  frame_done;

  modport master (
    output enable, lz_blank_en, value, value_valid,
    input  value_ready, digit_code, digit_sel, digit_blank, frame_done
  );

  modport slave (
    input  enable, lz_blank_en, value, value_valid,
    output value_ready, digit_code, digit_sel, digit_blank, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared decoder, DIGITS enables,
// tear-free value updates committed at frame boundaries, optional leading-zero blanking.
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [1:0]    ST_SLOT0   = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [4*DIGITS-1:0]   shown_q, shown_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic                  pfull_q, pfull_d;

  logic [3:0]            code_q, code_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  blank_q, blank_d;
  logic                  fdone_q, fdone_d;

  logic                  boundary;
  logic                  commit;
  logic                  lz_dark;
  logic [DIGITS-1:0]     zero_from;
  logic [3:0]            nib [DIGITS];

  // zero_from[i]: nibbles i..DIGITS-1 of the value about to be displayed are all zero
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib[gi]       = shown_d[4*gi +: 4];
      assign zero_from[gi] = ((shown_d >> (4*gi)) == '0);
    end
  endgenerate

  assign boundary = (state_q == ST_SHOW) && (idx_q == IDX_LAST) && (slot_q == SLOT_LAST);
  // A stopped scan never reaches a boundary, so commit immediately to keep the handshake moving
  assign commit   = pfull_q && (boundary || !bus.enable);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    pfull_d   = pfull_q;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      slot_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SLOT0;
          idx_d   = '0;
          slot_d  = '0;
        end
        ST_BLANK: begin
          if (slot_q == BLANK_LAST) state_d = ST_SHOW;
          slot_d = slot_q + 1'b1;
        end
        ST_SHOW: begin
          if (slot_q == SLOT_LAST) begin
            state_d = ST_SLOT0;
            slot_d  = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          slot_d  = '0;
        end
      endcase
    end

    // Commit and accept are exclusive: accept needs pending empty, commit needs it full
    if (commit) begin
      shown_d = pending_q;
      pfull_d = 1'b0;
    end else if (bus.value_valid && !pfull_q) begin
      pending_d = bus.value;
      pfull_d   = 1'b1;
    end
  end

  always_comb begin
    lz_dark = bus.lz_blank_en && (idx_d != '0) && zero_from[idx_d];
    code_d  = (state_d == ST_IDLE) ? 4'd0 : nib[idx_d];
    sel_d   = ((state_d == ST_SHOW) && !lz_dark) ? (DIGITS'(1) << idx_d) : '0;
    blank_d = (sel_d == '0);
    fdone_d = (state_d == ST_SHOW) && (idx_d == IDX_LAST) && (slot_d == SLOT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      slot_q    <= '0;
      shown_q   <= '0;
      pending_q <= '0;
      pfull_q   <= 1'b0;
      code_q    <= 4'd0;
      sel_q     <= '0;
      blank_q   <= 1'b1;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      slot_q    <= slot_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      pfull_q   <= pfull_d;
      code_q    <= code_d;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      fdone_q   <= fdone_d;
    end
  end

  assign bus.value_ready = !pfull_q;
  assign bus.digit_code  = code_q;
  assign bus.digit_sel   = sel_q;
  assign bus.digit_blank = blank_q;
  assign bus.frame_done  = fdone_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl, checked every cycle against a frame-position model.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  localparam int D = 4;
  localparam int S = 8;
  localparam int B = 2;
  localparam int F = D * S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: position within the frame since the scan (re)started
  bit          m_run;
  int          m_pos;
  logic [15:0] m_shown, m_pend;
  bit          m_pfull, m_accept, m_lz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_shown = '0; m_pend = '0; m_pfull = 0; m_accept = 0;
  endtask

  task automatic model_edge();
    bit bnd, com;
    m_accept = 0;
    if (rst) begin
      model_reset();
      return;
    end
    m_lz = bus.lz_blank_en;
    bnd  = m_run && (m_pos == F - 1);
    com  = m_pfull && (!bus.enable || bnd);
    if (com) begin
      m_shown = m_pend;
      m_pfull = 0;
    end else if (bus.value_valid && !m_pfull) begin
      m_pend   = bus.value;
      m_pfull  = 1;
      m_accept = 1;
      $display("cycle %0d: accepted value %04h", cyc, bus.value);
    end
    if (!bus.enable) begin
      m_run = 0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % F;
    end
  endtask

  task automatic check_outputs();
    int slot, ph;
    logic [3:0] e_sel, e_code;
    logic [15:0] v;
    bit e_fd, lit;
    e_sel = '0; e_code = '0; e_fd = 0;
    if (m_run) begin
      slot   = m_pos / S;
      ph     = m_pos % S;
      v      = m_shown;
      e_code = v[4*slot +: 4];
      lit    = (ph >= B) && !(m_lz && slot != 0 && (m_shown >> (4*slot)) == 16'd0);
      e_sel  = lit ? 4'(1 << slot) : 4'd0;
      e_fd   = (m_pos == F - 1);
    end
    check_eq("digit_sel",   32'(bus.digit_sel),   32'(e_sel));
    check_eq("digit_blank", 32'(bus.digit_blank), 32'(e_sel == 4'd0));
    check_eq("digit_code",  32'(bus.digit_code),  32'(e_code));
    check_eq("frame_done",  32'(bus.frame_done),  32'(e_fd));
    check_eq("value_ready", 32'(bus.value_ready), 32'(!m_pfull));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_outputs();
  endtask

  // Hold value_valid until the model says it was taken; bounded wait
  task automatic offer(input logic [15:0] v);
    bus.value = v;
    bus.value_valid = 1'b1;
    for (int i = 0; i < 4*F; i++) begin
      step();
      if (m_accept) begin
        bus.value_valid = 1'b0;
        return;
      end
    end
    bus.value_valid = 1'b0;
    check_eq("offer_timeout", 32'(bus.value_ready), 32'd1);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2*F; i++) begin
      if (m_run && m_pos == p) return;
      step();
    end
    check_eq("wait_pos_timeout", 32'(m_pos), 32'(p));
  endtask

  task automatic wait_commit();
    for (int i = 0; i < 3*F; i++) begin
      if (!m_pfull) return;
      step();
    end
    check_eq("commit_timeout", 32'(bus.value_ready), 32'd1);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = 16'($urandom);
    for (int i = 0; i < 4; i++) if ($urandom_range(1, 0) == 0) v[4*i +: 4] = 4'd0;
    return v;
  endfunction

  initial begin
    logic [3:0] or_sel;
    int off_cnt;

    rst = 1'b1;
    bus.enable = 1'b0; bus.lz_blank_en = 1'b0; bus.value = '0; bus.value_valid = 1'b0;
    model_reset();
    m_lz = 0;
    #1;
    check_outputs();
    step(); step();
    rst = 1'b0;

    // Free-running scan with an all-zero value
    bus.enable = 1'b1;
    repeat (2*F + 2) step();

    // First value, then a second held off until the first commits
    offer(16'h1234);
    offer(16'hABCD);
    repeat (2*F) step();

    // Leading-zero blanking
    bus.lz_blank_en = 1'b1;
    offer(16'h0050);
    wait_commit();
    or_sel = '0;
    repeat (F) begin step(); or_sel |= bus.digit_sel; end
    check_eq("lz_0050_lit", 32'(or_sel), 32'h3);
    offer(16'h0000);
    wait_commit();
    or_sel = '0;
    repeat (F) begin step(); or_sel |= bus.digit_sel; end
    check_eq("lz_zero_lit", 32'(or_sel), 32'h1);

    // Drop enable mid-SHOW of digit 2, then restart
    bus.lz_blank_en = 1'b0;
    offer(16'h8765);
    wait_commit();
    wait_pos(2*S + 4);
    bus.enable = 1'b0;
    step();
    check_eq("drop_sel_dark", 32'(bus.digit_sel), 32'd0);
    step(); step();
    bus.enable = 1'b1;
    repeat (F + 4) step();

    // Randomized traffic with occasional stops and blanking toggles
    off_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!bus.value_valid && $urandom_range(3, 0) == 0) begin
        bus.value = rand_value();
        bus.value_valid = 1'b1;
      end
      if (off_cnt > 0) begin
        off_cnt--;
        bus.enable = (off_cnt == 0);
      end else if ($urandom_range(149, 0) == 0) begin
        off_cnt = $urandom_range(10, 1);
        bus.enable = 1'b0;
      end
      if ($urandom_range(63, 0) == 0) bus.lz_blank_en = ~bus.lz_blank_en;
      step();
      if (m_accept) bus.value_valid = 1'b0;
    end
    bus.enable = 1'b1;
    bus.value_valid = 1'b0;
    wait_commit();

    // Asynchronous reset mid-frame with a value pending
    wait_pos(0);
    offer(16'h9999);
    repeat (5) step();
    check_eq("pending_before_rst", 32'(bus.value_ready), 32'd0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check_eq("rst_ready", 32'(bus.value_ready), 32'd1);
    step(); step();
    rst = 1'b0;
    repeat (F + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
